// File: rtl/tc_pl_gate_ctrl_pkg.sv
// Shared definitions for the gate controller and its GPIO glue:
// the FSM state encoding and the default widths and guard length.
package tc_pl_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_GUARD = 2'd2
  } gate_state_t;

  localparam int unsigned TOP0_0_DEF = 3;
  localparam int unsigned LDD0_0_DEF = 32;
  localparam int unsigned GUARD_DEF  = 16;

endpackage

// File: rtl/tc_pl_edge_det.sv
// Two-flop rising-edge detector with synchronous active-low clear.
// The first flop is the registered copy of the input; the second holds its previous value.
module tc_pl_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  logic stage_r;
  logic prev_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      stage_r <= din;
      prev_r  <= stage_r;
    end
  end

  assign evt = stage_r & ~prev_r;

endmodule

// File: rtl/tc_pl_gate_ctrl.sv
// Gate controller: edge-detected open/close commands drive a timed or held
// channel window, followed by a fixed guard interval.
module tc_pl_gate_ctrl
  import tc_pl_gate_ctrl_pkg::*;
#(
  parameter int unsigned TOP0_0 = TOP0_0_DEF,
  parameter int unsigned LDD0_0 = LDD0_0_DEF,
  parameter int unsigned GUARD  = GUARD_DEF
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic [TOP0_0-1:0] Gc_com_wdis,
  input  logic [LDD0_0-1:0] Gc_com_plus,
  input  logic              Gc_com_open,
  input  logic              Gc_com_close,
  output logic [TOP0_0-1:0] Gc_wdis,
  output logic              Gc_busy
);

  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

  logic [TOP0_0-1:0] mask_r;
  logic [LDD0_0-1:0] plus_r;
  logic              open_evt;
  logic              close_evt;

  gate_state_t       state, state_n;
  logic [TOP0_0-1:0] mask_q, mask_n;
  logic [LDD0_0-1:0] cnt, cnt_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic [TOP0_0-1:0] wdis_q;
  logic              busy_q;

  // Stage R for the data words; open/close get theirs inside the edge detectors.
  always_ff @(posedge clk125) begin
    if (!rst) begin
      mask_r <= '0;
      plus_r <= '0;
    end else begin
      mask_r <= Gc_com_wdis;
      plus_r <= Gc_com_plus;
    end
  end

  tc_pl_edge_det u_open_det (
    .clk (clk125),
    .rst (rst),
    .din (Gc_com_open),
    .evt (open_evt)
  );

  tc_pl_edge_det u_close_det (
    .clk (clk125),
    .rst (rst),
    .din (Gc_com_close),
    .evt (close_evt)
  );

  always_ff @(posedge clk125) begin
    if (!rst) begin
      state  <= ST_IDLE;
      mask_q <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      wdis_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      mask_q <= mask_n;
      cnt    <= cnt_n;
      gcnt   <= gcnt_n;
      wdis_q <= (state == ST_OPEN) ? mask_q : '0;
      busy_q <= (state != ST_IDLE);
    end
  end

  // A zero cnt while OPEN means a hold window: a timed window always leaves at cnt == 1.
  always_comb begin
    state_n = state;
    mask_n  = mask_q;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    unique case (state)
      ST_IDLE: begin
        if (open_evt && (mask_r != '0)) begin
          mask_n  = mask_r;
          cnt_n   = plus_r;
          state_n = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (close_evt) begin
          cnt_n   = '0;
          gcnt_n  = GW'(GUARD);
          state_n = ST_GUARD;
        end else if (open_evt && (mask_r != '0)) begin
          mask_n = mask_r;
          cnt_n  = plus_r;
        end else if (cnt == LDD0_0'(1)) begin
          cnt_n   = '0;
          gcnt_n  = GW'(GUARD);
          state_n = ST_GUARD;
        end else if (cnt != '0) begin
          cnt_n = cnt - LDD0_0'(1);
        end
      end
      ST_GUARD: begin
        if (gcnt <= GW'(1)) begin
          gcnt_n  = '0;
          state_n = ST_IDLE;
        end else begin
          gcnt_n = gcnt - GW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign Gc_wdis = wdis_q;
  assign Gc_busy = busy_q;

endmodule

// File: tb/tb_tc_pl_gate_ctrl.sv
// Scoreboard bench for tc_pl_gate_ctrl: each scenario queues the expected
// per-cycle (Gc_wdis, Gc_busy) trace, then steps the clock and pops/compares.
module tb_tc_pl_gate_ctrl;

  logic        clk125 = 1'b0;
  logic        rst;
  logic [2:0]  Gc_com_wdis;
  logic [31:0] Gc_com_plus;
  logic        Gc_com_open;
  logic        Gc_com_close;
  logic [2:0]  Gc_wdis;
  logic        Gc_busy;

  typedef struct {
    logic [2:0] w;
    logic       b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  tc_pl_gate_ctrl #(
    .TOP0_0 (3),
    .LDD0_0 (32),
    .GUARD  (16)
  ) dut (
    .clk125       (clk125),
    .rst          (rst),
    .Gc_com_wdis  (Gc_com_wdis),
    .Gc_com_plus  (Gc_com_plus),
    .Gc_com_open  (Gc_com_open),
    .Gc_com_close (Gc_com_close),
    .Gc_wdis      (Gc_wdis),
    .Gc_busy      (Gc_busy)
  );

  always #4 clk125 = ~clk125;

  task automatic step();
    @(posedge clk125);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] w, input logic b, input int n);
    exp_t x;
    x.w = w;
    x.b = b;
    for (int i = 0; i < n; i++) sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    Gc_com_wdis = '0; Gc_com_plus = '0; Gc_com_open = 1'b0; Gc_com_close = 1'b0;
    push_exp(3'b000, 1'b0, 2);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL reset cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
    end
    rst = 1'b1;
    step(); step();
  endtask

  task automatic test_timed();
    Gc_com_wdis = 3'b101; Gc_com_plus = 32'd10; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b101, 1'b1, 10);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 3);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL timed cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
    end
  endtask

  task automatic test_min_duration();
    Gc_com_wdis = 3'b010; Gc_com_plus = 32'd1; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b010, 1'b1, 1);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 2);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL min_dur cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
    end
  endtask

  task automatic test_hold_close();
    Gc_com_wdis = 3'b010; Gc_com_plus = 32'd0; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b010, 1'b1, 1002);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 2);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL hold_close cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1)    Gc_com_open  = 1'b0;
      if (i == 1002) Gc_com_close = 1'b1;
      if (i == 1003) Gc_com_close = 1'b0;
    end
  endtask

  task automatic test_retrigger();
    Gc_com_wdis = 3'b001; Gc_com_plus = 32'd20; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b001, 1'b1, 7);
    push_exp(3'b100, 1'b1, 4);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 3);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL retrigger cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
      if (i == 7) begin
        Gc_com_wdis = 3'b100; Gc_com_plus = 32'd4; Gc_com_open = 1'b1;
      end
      if (i == 8) Gc_com_open = 1'b0;
    end
    // zero mask from IDLE opens nothing
    Gc_com_wdis = 3'b000; Gc_com_plus = 32'd5; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 12);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL zero_mask cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
    end
  endtask

  task automatic test_guard_reject();
    Gc_com_wdis = 3'b011; Gc_com_plus = 32'd3; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b011, 1'b1, 3);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 10);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL guard_reject cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
      if (i == 8) begin
        Gc_com_wdis = 3'b111; Gc_com_plus = 32'd5; Gc_com_open = 1'b1;
      end
      if (i == 9) Gc_com_open = 1'b0;
    end
  endtask

  task automatic test_priority();
    Gc_com_wdis = 3'b110; Gc_com_plus = 32'd0; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b110, 1'b1, 5);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 4);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL priority cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
      if (i == 5) begin
        Gc_com_wdis = 3'b001; Gc_com_open = 1'b1; Gc_com_close = 1'b1;
      end
      if (i == 6) begin
        Gc_com_open = 1'b0; Gc_com_close = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    Gc_com_wdis = 3'b111; Gc_com_plus = 32'd100; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b111, 1'b1, 8);
    push_exp(3'b000, 1'b0, 4);
    push_exp(3'b101, 1'b1, 5);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 10);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL reset_mid cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 10) begin
        rst = 1'b0; Gc_com_wdis = 3'b101; Gc_com_plus = 32'd5;
      end
      if (i == 12) rst = 1'b1;
    end
    Gc_com_open = 1'b0;
    step(); step();
  endtask

  task automatic test_long();
    logic [31:0] exp_cnt;
    Gc_com_wdis = 3'b001; Gc_com_plus = 32'hFFFF_FFFF; Gc_com_open = 1'b1;
    push_exp(3'b000, 1'b0, 2);
    push_exp(3'b001, 1'b1, 300);
    push_exp(3'b000, 1'b1, 16);
    push_exp(3'b000, 1'b0, 2);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      e = sb.pop_front();
      total++;
      if (Gc_wdis !== e.w || Gc_busy !== e.b)
        $display("FAIL long cyc %0d: wdis=%b busy=%b, expected wdis=%b busy=%b", i, Gc_wdis, Gc_busy, e.w, e.b);
      else passed++;
      if (i == 1) Gc_com_open = 1'b0;
      if (i == 300) begin
        exp_cnt = 32'hFFFF_FFFF - 32'd298;
        total++;
        if (dut.cnt !== exp_cnt)
          $display("FAIL long_cnt: cnt=%h, expected %h", dut.cnt, exp_cnt);
        else passed++;
        Gc_com_close = 1'b1;
      end
      if (i == 301) Gc_com_close = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_timed();
    test_min_duration();
    test_hold_close();
    test_retrigger();
    test_guard_reject();
    test_priority();
    test_reset_mid();
    test_long();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
